// File: rtl/rfsoc_config.sv
// Shared RFSoC configuration constants: gpio_ctrl bit map, config register width
// and the ADC capture state encoding.
package rfsoc_config;

    localparam int unsigned config_reg_width = 16;
    localparam int unsigned DECIM_W          = 8;

    // gpio_ctrl bit map: one serial data line plus one shift clock per register
    localparam int unsigned sdata         = 0;
    localparam int unsigned adc_delay_clk = 1;
    localparam int unsigned adc_count_clk = 2;
    localparam int unsigned adc_decim_clk = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELAY   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_e;

endpackage

// File: rtl/shift_register.sv
// Serial config register: shifts sdata in MSB-first on each rising edge of its
// gpio shift clock while enabled. Both gpio lines are registered once before use.
module shift_register #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             sclk_i,
    input  logic             sdata_i,
    output logic [WIDTH-1:0] q_o
);

    logic             sclk_q;
    logic             sclk_prev_q;
    logic             sdata_q;
    logic [WIDTH-1:0] shreg_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_q      <= 1'b0;
            sclk_prev_q <= 1'b0;
            sdata_q     <= 1'b0;
            shreg_q     <= '0;
        end else begin
            sclk_q      <= sclk_i;
            sclk_prev_q <= sclk_q;
            sdata_q     <= sdata_i;
            if (en_i && sclk_q && !sclk_prev_q) begin
                shreg_q <= {shreg_q[WIDTH-2:0], sdata_q};
            end
        end
    end

    assign q_o = shreg_q;

endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: after a trigger and programmed delay, forwards a programmed
// number of decimated ADC words to the capture FIFO. Optional: ADC_CAPTURE_TIMESTAMP_EN.
module adc_capture_ctrl
    import rfsoc_config::*;
#(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned TS_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    input  logic [15:0]       gpio_ctrl,
    input  logic              trigger_in,
    input  logic              select_in,
    output logic              capture_busy,
    output logic              capture_done,
    output logic              overflow,
    output logic [TS_W-1:0]   trigger_timestamp
);

    localparam int unsigned CW = config_reg_width;

    logic [CW-1:0]      delay_cfg;
    logic [CW-1:0]      count_cfg;
    logic [DECIM_W-1:0] decim_cfg;

    cap_state_e         state_q,  state_d;
    logic [CW-1:0]      dly_cnt_q, dly_cnt_d;
    logic [CW-1:0]      cap_cnt_q, cap_cnt_d;
    logic [DECIM_W-1:0] dec_cnt_q, dec_cnt_d;
    logic [DECIM_W-1:0] decim_q,   decim_d;
    logic [DATA_W-1:0]  tdata_q,   tdata_d;
    logic               tvalid_q,  tvalid_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic               ovf_q,     ovf_d;
    logic               latch_ts;
    logic               unused_gpio;

    shift_register #(.WIDTH(CW)) u_delay_reg (
        .clk     (clk),
        .rst     (rst),
        .en_i    (select_in),
        .sclk_i  (gpio_ctrl[adc_delay_clk]),
        .sdata_i (gpio_ctrl[sdata]),
        .q_o     (delay_cfg)
    );

    shift_register #(.WIDTH(CW)) u_count_reg (
        .clk     (clk),
        .rst     (rst),
        .en_i    (select_in),
        .sclk_i  (gpio_ctrl[adc_count_clk]),
        .sdata_i (gpio_ctrl[sdata]),
        .q_o     (count_cfg)
    );

    shift_register #(.WIDTH(DECIM_W)) u_decim_reg (
        .clk     (clk),
        .rst     (rst),
        .en_i    (select_in),
        .sclk_i  (gpio_ctrl[adc_decim_clk]),
        .sdata_i (gpio_ctrl[sdata]),
        .q_o     (decim_cfg)
    );

    assign unused_gpio = ^gpio_ctrl[15:4];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            dly_cnt_q <= '0;
            cap_cnt_q <= '0;
            dec_cnt_q <= '0;
            decim_q   <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dly_cnt_q <= dly_cnt_d;
            cap_cnt_q <= cap_cnt_d;
            dec_cnt_q <= dec_cnt_d;
            decim_q   <= decim_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

    // Next-state and registered-output logic; the FIFO is never waited on, a refused word is lost.
    always_comb begin
        state_d   = state_q;
        dly_cnt_d = dly_cnt_q;
        cap_cnt_d = cap_cnt_q;
        dec_cnt_d = dec_cnt_q;
        decim_d   = decim_q;
        tdata_d   = tdata_q;
        tvalid_d  = 1'b0;
        ovf_d     = ovf_q | (tvalid_q & ~m_axis_tready);
        latch_ts  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (trigger_in) begin
                    dly_cnt_d = delay_cfg;
                    cap_cnt_d = count_cfg;
                    decim_d   = decim_cfg;
                    ovf_d     = 1'b0;
                    state_d   = DELAY;
                end
            end
            DELAY: begin
                if (dly_cnt_q == '0) begin
                    dec_cnt_d = '0;
                    latch_ts  = 1'b1;
                    state_d   = CAPTURE;
                end else begin
                    dly_cnt_d = dly_cnt_q - CW'(1);
                end
            end
            CAPTURE: begin
                if (cap_cnt_q == '0) begin
                    state_d = DONE;
                end else if (s_axis_tvalid) begin
                    if (dec_cnt_q == '0) begin
                        tvalid_d  = 1'b1;
                        tdata_d   = s_axis_tdata;
                        cap_cnt_d = cap_cnt_q - CW'(1);
                    end
                    dec_cnt_d = (dec_cnt_q == decim_q) ? '0 : dec_cnt_q + DECIM_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == DELAY) || (state_d == CAPTURE);
        done_d = (state_d == DONE);
    end

    assign s_axis_tready = 1'b1;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign capture_busy  = busy_q;
    assign capture_done  = done_q;
    assign overflow      = ovf_q;

`ifdef ADC_CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_q;
    logic [TS_W-1:0] ts_q;

    // Timestamp is the counter value during the first CAPTURE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_cnt_q <= '0;
            ts_q     <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + TS_W'(1);
            if (latch_ts) begin
                ts_q <= ts_cnt_q + TS_W'(1);
            end
        end
    end

    assign trigger_timestamp = ts_q;
`else
    logic unused_ts;
    assign unused_ts         = latch_ts;
    assign trigger_timestamp = '0;
`endif

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
- Receive-side counterpart of the DAC playback controller.
- Sits between the RFSoC Data Converter ADC AXI-Stream output and the per-channel capture FIFO.
- On trigger_in, waits a programmed number of delay cycles, then forwards a programmed number of (optionally decimated) 256-bit ADC words into the capture FIFO, then signals completion.
- Configured serially from the PS over the gpio_ctrl bus, gated by select_in.

Parameters:
- DATA_W, 256, ADC/FIFO stream width in bits.
- TS_W, 32, timestamp width; used only with the optional feature.

Ports:
- clk  input  1  250 MHz clock from RFSoC IP.
- rst  input  1  asynchronous, active-low reset.
- s_axis_tdata  input  DATA_W  ADC sample words from RFSoC IP.
- s_axis_tvalid  input  1  ADC word valid.
- s_axis_tready  output  1  constant 1; the ADC is never stalled.
- m_axis_tdata  output  DATA_W  word to capture FIFO.
- m_axis_tvalid  output  1  word valid to capture FIFO.
- m_axis_tready  input  1  capture FIFO can accept.
- gpio_ctrl  input  16  PS serial config bus: sdata plus per-register shift clocks.
- trigger_in  input  1  synchronization trigger, level-sampled.
- select_in  input  1  1 = PS is configuring this channel.
- capture_busy  output  1  high in DELAY and CAPTURE.
- capture_done  output  1  one-cycle pulse at end of capture.
- overflow  output  1  sticky: a word was dropped because m_axis_tready was low.
- trigger_timestamp  output  TS_W  free-running count latched at CAPTURE entry; 0 when the optional feature is absent.

Behaviour:
- Config registers are shift_register instances clocked by clk & select_in, each with its own gpio_ctrl shift-clock bit, all sharing gpio_ctrl[sdata]:
  - delay_cycles, config_reg_width bits.
  - capture_count, config_reg_width bits.
  - decim, 8 bits.
- Config registers are sampled only on leaving IDLE. PS writes mid-capture do not affect the capture in progress.
- Reset (asynchronous, active-low): state=IDLE; m_axis_tvalid=0; m_axis_tdata=0; capture_busy=0; capture_done=0; overflow=0; all counters=0; trigger_timestamp=0.
- States:
  - IDLE: when trigger_in=1, load dly_cnt<=delay_cycles, cap_cnt<=capture_count, clear overflow, go to DELAY.
  - DELAY: when dly_cnt==0, reset dec_cnt<=0 and go to CAPTURE; otherwise decrement dly_cnt. This gives delay_cycles+1 cycles in DELAY.
  - CAPTURE:
    - cap_cnt==0: go to DONE.
    - Otherwise, a beat with s_axis_tvalid=1 and dec_cnt==0 is a sample. On a sample: register s_axis_tdata to m_axis_tdata, assert m_axis_tvalid the next cycle for exactly one cycle, decrement cap_cnt.
    - dec_cnt counts valid beats modulo decim+1, so the first valid beat in CAPTURE is always sampled.
  - DONE: pulse capture_done for one cycle, return to IDLE.
- Latency: m_axis_tvalid asserts 1 cycle after the sampled input beat.
- Non-stalling rule: if m_axis_tvalid=1 and m_axis_tready=0, the word is dropped and overflow is set. The word still counts toward cap_cnt, and the next word overwrites it.
- overflow stays set until the next accepted trigger or reset.
- trigger_in is ignored outside IDLE. If trigger_in stays high after DONE, a new capture starts on the first IDLE cycle.
- capture_count=0: IDLE → DELAY → CAPTURE → DONE with no m_axis beats; capture_done still pulses.
- s_axis_tvalid=0 during CAPTURE: no sample is taken, dec_cnt holds, cap_cnt holds.
- Counter widths: dly_cnt and cap_cnt are config_reg_width bits; no wrap, because they only decrement while nonzero.

Optional Feature:
- Macro: ADC_CAPTURE_TIMESTAMP_EN.
- Defined:
  - A TS_W-bit counter free-runs from reset and wraps at 2^TS_W.
  - trigger_timestamp latches its value on the DELAY→CAPTURE transition and holds until the next one.
- Undefined: counter is omitted; trigger_timestamp is tied to 0.

Decomposition:
- rfsoc_config package gains gpio_ctrl bit indices adc_delay_clk, adc_count_clk and adc_decim_clk.
- The package also gains a typedef for the capture state enum (IDLE, DELAY, CAPTURE, DONE).
- config_reg_width and sdata are reused from the package.
- Sub-module: the existing shared shift_register, instantiated three times. No new sub-module.

Test Plan:
- delay=3, count=4, decim=0, tvalid=1, tready=1, pulse trigger → first m_axis_tvalid 6 cycles after the trigger edge; 4 consecutive beats equal to the inputs; capture_done one cycle later; overflow=0.
- decim=2, count=3, input words numbered 0..20 → m_axis carries words 0, 3, 6 (relative to CAPTURE entry); then done.
- count=5, tready forced 0 on the 2nd output beat → overflow=1 and sticky; exactly 5 tvalid beats; a new trigger clears overflow.
- count=0 → no m_axis_tvalid; capture_done pulses; capture_busy high for delay_cycles+2 cycles.
- rst low mid-CAPTURE after 2 beats → all outputs at reset values immediately; a new trigger restarts a full count.
- With ADC_CAPTURE_TIMESTAMP_EN: trigger at counter value 100, delay=5 → trigger_timestamp=107. Without the macro → trigger_timestamp=0.
